logic_reduce_unit: RTL and testbench

- Parametrised, clocked successor to the single-bit primitive OR gate.
- Accepts a stream of WIDTH-bit operands under valid/ready handshake and reduces them bitwise with a selectable boolean op (AND/OR/XOR/NAND/NOR/XNOR).
- Presents one registered result per packet on a valid/ready output.
- Sits between operand producers and downstream logic wherever a multi-operand gate over time is needed.

---
 rtl/logic_reduce_unit.sv | 139 +++++++++++++
 tb/tb_logic_reduce_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_reduce_unit.sv
// Streaming multi-operand boolean reducer: folds a packet of WIDTH-bit beats
// with AND/OR/XOR (optionally inverted) and presents one registered result.
module logic_reduce_unit #(
   parameter int WIDTH   = 8,
   parameter int MAX_OPS = 16,
   parameter int CNT_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op_sel,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             trunc_q, trunc_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_err_q, out_err_d;
   logic             beat;
   logic             finish;

   function automatic logic [WIDTH-1:0] base_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      case (op)
         3'd0, 3'd3: base_op = a & b;
         3'd1, 3'd4: base_op = a | b;
         3'd2, 3'd5: base_op = a ^ b;
         default:    base_op = a | b;
      endcase
   endfunction

   // Ready is a pure decode of state (and reset), so out_ready never reaches it.
   assign in_ready  = !rst && (state_q != S_DONE);
   assign out_valid = (state_q == S_DONE);
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_err   = out_err_q;

   assign beat = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      count_d     = count_q;
      trunc_d     = trunc_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_err_d   = out_err_q;
      finish      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (beat) begin
               op_d    = op_sel;
               acc_d   = in_data;
               count_d = CNT_W'(1);
               trunc_d = 1'b0;
               finish  = in_last;
               state_d = in_last ? S_DONE : S_ACC;
            end
         end
         S_ACC: begin
            if (beat) begin
               acc_d   = base_op(op_q, acc_q, in_data);
               count_d = count_q + CNT_W'(1);
               // Hitting the operand limit closes the packet even without in_last.
               if (in_last || (count_d == MAX_CNT)) begin
                  finish  = 1'b1;
                  trunc_d = !in_last;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
               acc_d   = '0;
               count_d = '0;
               trunc_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Result registers are loaded once, on the edge that enters DONE.
      if (finish) begin
         if (op_d > 3'd5)
            out_data_d = '0;
         else if (op_d >= 3'd3)
            out_data_d = ~acc_d;
         else
            out_data_d = acc_d;
         out_count_d = count_d;
         out_err_d   = (op_d > 3'd5) | trunc_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         acc_q       <= '0;
         count_q     <= '0;
         trunc_q     <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         trunc_q     <= trunc_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_err_q   <= out_err_d;
      end
   end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Scoreboard bench for logic_reduce_unit: directed packets plus random traffic,
// expected results come from a packet-level reference model.
module tb_logic_reduce_unit;

   localparam int WIDTH   = 8;
   localparam int MAX_OPS = 4;
   localparam int CNT_W   = 5;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [CNT_W-1:0] count;
      logic             err;
   } expected_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [2:0]       op_sel = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_err;

   int compared = 0;
   int mismatched = 0;
   logic holdReady = 1'b1;

   expected_t        expQ[$];
   logic [WIDTH-1:0] pktOps[$];
   logic [2:0]       pktOp;

   logic_reduce_unit #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .op_sel(op_sel), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_err(out_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      out_ready = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   function automatic logic [WIDTH-1:0] reduceModel(input logic [2:0] op,
                                                    input logic [WIDTH-1:0] ops[$]);
      logic [WIDTH-1:0] r;
      if (op > 3'd5) return '0;
      r = ops[0];
      for (int i = 1; i < ops.size(); i++) begin
         case (op % 3)
            0: r = r & ops[i];
            1: r = r | ops[i];
            default: r = r ^ ops[i];
         endcase
      end
      return (op >= 3'd3) ? ~r : r;
   endfunction

   task automatic modelBeat(input logic [2:0] op, input logic [WIDTH-1:0] d,
                            input logic last);
      expected_t e;
      if (pktOps.size() == 0) pktOp = op;
      pktOps.push_back(d);
      if (last || pktOps.size() == MAX_OPS) begin
         e.data  = reduceModel(pktOp, pktOps);
         e.count = CNT_W'(pktOps.size());
         e.err   = (pktOp > 3'd5) || (!last && pktOps.size() == MAX_OPS);
         expQ.push_back(e);
         pktOps.delete();
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Drive one beat (called just after a rising edge) and wait for acceptance.
   task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                input logic last);
      logic rdy;
      int   guard;
      op_sel = op; in_data = d; in_last = last; in_valid = 1'b1;
      guard = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!rdy && guard < 200);
      in_valid = 1'b0;
      if (rdy) modelBeat(op, d, last);
      else checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int guard;
      holdReady = 1'b0;
      guard = 0;
      while (expQ.size() != 0 && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
   endtask

   always @(negedge clk) begin
      expected_t e;
      if (!rst && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_result", 32'd1, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("out_data", out_data, e.data);
            checkOutput("out_count", out_count, e.count);
            checkOutput("out_err", out_err, e.err);
         end
      end
   end

   initial begin
      #1;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_out_data", out_data, 0);
      checkOutput("reset_out_err", out_err, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 checkOutput("idle_in_ready", in_ready, 1);
      holdReady = 1'b0;

      applyStimulus(3'd1, 8'h01, 1'b0);
      applyStimulus(3'd1, 8'h10, 1'b0);
      applyStimulus(3'd1, 8'h80, 1'b1);
      applyStimulus(3'd3, 8'hF0, 1'b0);
      applyStimulus(3'd3, 8'h3C, 1'b1);
      applyStimulus(3'd5, 8'hAA, 1'b0);
      applyStimulus(3'd5, 8'h0F, 1'b1);
      applyStimulus(3'd2, 8'h01, 1'b0);
      applyStimulus(3'd2, 8'h02, 1'b0);
      applyStimulus(3'd2, 8'h04, 1'b0);
      applyStimulus(3'd2, 8'h08, 1'b0);
      applyStimulus(3'd2, 8'h55, 1'b1);
      applyStimulus(3'd7, 8'hFF, 1'b1);
      applyStimulus(3'd0, 8'h3C, 1'b1);
      drain();

      // Backpressure: result held while a new beat waits.
      holdReady = 1'b1;
      applyStimulus(3'd1, 8'h01, 1'b0);
      applyStimulus(3'd1, 8'h10, 1'b0);
      applyStimulus(3'd1, 8'h80, 1'b1);
      op_sel = 3'd0; in_data = 8'h33; in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp_in_ready", in_ready, 0);
         checkOutput("bp_out_valid", out_valid, 1);
         checkOutput("bp_out_data", out_data, 8'h91);
         checkOutput("bp_out_count", out_count, 3);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();
      applyStimulus(3'd0, 8'h33, 1'b1);
      drain();

      // Async reset while a result is pending.
      holdReady = 1'b1;
      applyStimulus(3'd1, 8'hA5, 1'b1);
      @(posedge clk);
      #3 rst = 1'b1;
      expQ.delete();
      #1;
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_out_data", out_data, 0);
      checkOutput("midrst_out_err", out_err, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Reset in the middle of a packet discards it.
      holdReady = 1'b0;
      applyStimulus(3'd0, 8'h0F, 1'b0);
      applyStimulus(3'd0, 8'hFF, 1'b0);
      #2 rst = 1'b1;
      pktOps.delete();
      #1 checkOutput("pktrst_in_ready", in_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      applyStimulus(3'd4, 8'h81, 1'b0);
      applyStimulus(3'd4, 8'h18, 1'b1);
      drain();

      for (int p = 0; p < 40; p++) begin
         int len;
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), b == len - 1);
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
